s_seq_div4: RTL and testbench

S_SEQ_DIV4 -- requirements
Module: s_seq_div4

---
 rtl/s_seq_div4.sv | 200 ++++++++++++++++++++
 tb/tb_s_seq_div4.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_seq_div4.sv
`default_nettype none
// ============================================================================
// Module      : s_seq_div4
// Description : Sequential signed divider, 8-bit dividend by 4-bit divisor.
//               Operands are converted to magnitudes, divided by an unsigned
//               restoring shift/subtract loop (one quotient bit per cycle,
//               MSB first), then signs are applied. Division truncates toward
//               zero; the remainder carries the sign of the dividend.
//               Fixed latency: accept at edge N, result valid from edge N+9.
// Revision    : 1.0 - initial release
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   a              signed dividend (8 bits)
//   b              signed divisor  (4 bits)
//   in_valid       operand request
//   in_ready       high only while idle
//   s_seq_div4_out [3:0] signed quotient, [7:4] signed remainder
//   dbz            divide-by-zero flag for the current result
//   ovf            quotient outside -8..7 for the current result
//   out_valid      result present
//   out_ready      consumer accepts the result
//
// Build option
//   S_SEQ_DIV4_OVF_SAT_EN : when defined, an overflowing quotient saturates
//                           to 4'h7 / 4'h8; otherwise it wraps (low 4 bits).
// ============================================================================
module s_seq_div4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [3:0] b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] s_seq_div4_out,
    output logic       dbz,
    output logic       ovf,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] C_LAST_STEP = 4'd7;

    state_t     r_state;
    state_t     w_next;

    // Operand copies kept only to the extent the sign/fix-up stage needs them
    logic       r_a_sign;
    logic [3:0] r_a_lo;
    logic [3:0] r_b;

    // Division datapath
    logic [7:0] r_dvd;      // dividend magnitude, shifted out MSB first
    logic [3:0] r_babs;     // divisor magnitude (0..8)
    logic [3:0] r_rem;      // partial remainder, always < |b| <= 8
    logic [7:0] r_quo;      // quotient magnitude (0..128)
    logic [3:0] r_cnt;

    // Registered results
    logic [7:0] r_out;
    logic       r_dbz;
    logic       r_ovf;
    logic       r_out_valid;

    // Input magnitudes. An unsigned 8-bit result represents |-128| = 128
    // exactly, and 4 bits hold |-8| = 8, so no extra width is needed.
    logic [7:0] w_a_abs;
    logic [3:0] w_b_abs;
    assign w_a_abs = a[7] ? (8'd0 - a) : a;
    assign w_b_abs = b[3] ? (4'd0 - b) : b;

    // One restoring step. Because r_rem < |b| <= 8, the shifted value is at
    // most 15 plus a carry bit, and a successful subtraction leaves < 8, so
    // the 4-bit modular difference is exact whenever it is used.
    logic [4:0] w_shift;
    logic       w_ge;
    logic [3:0] w_sub;
    assign w_shift = {r_rem, r_dvd[7]};
    assign w_ge    = (w_shift >= {1'b0, r_babs});
    assign w_sub   = w_shift[3:0] - r_babs;

    // Sign fix-up
    logic       w_neg;
    logic       w_q_ovf;
    logic [3:0] w_q_wrap;
    logic [3:0] w_q_final;
    logic [3:0] w_r_final;
    assign w_neg    = r_a_sign ^ r_b[3];
    // A negative quotient may reach -8, a positive one only 7
    assign w_q_ovf  = w_neg ? (r_quo > 8'd8) : (r_quo > 8'd7);
    assign w_q_wrap = w_neg ? (4'd0 - r_quo[3:0]) : r_quo[3:0];
`ifdef S_SEQ_DIV4_OVF_SAT_EN
    assign w_q_final = w_q_ovf ? (w_neg ? 4'h8 : 4'h7) : w_q_wrap;
`else
    assign w_q_final = w_q_wrap;
`endif
    assign w_r_final = r_a_sign ? (4'd0 - r_rem) : r_rem;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid)              w_next = CALC;
            CALC: if (r_cnt == C_LAST_STEP)  w_next = FIX;
            FIX:                             w_next = DONE;
            DONE: if (out_ready)             w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sign    <= 1'b0;
            r_a_lo      <= 4'd0;
            r_b         <= 4'd0;
            r_dvd       <= 8'd0;
            r_babs      <= 4'd0;
            r_rem       <= 4'd0;
            r_quo       <= 8'd0;
            r_cnt       <= 4'd0;
            r_out       <= 8'd0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sign <= a[7];
                        r_a_lo   <= a[3:0];
                        r_b      <= b;
                        r_dvd    <= w_a_abs;
                        r_babs   <= w_b_abs;
                        r_rem    <= 4'd0;
                        r_quo    <= 8'd0;
                        r_cnt    <= 4'd0;
                    end
                end
                CALC: begin
                    r_rem <= w_ge ? w_sub : w_shift[3:0];
                    r_quo <= {r_quo[6:0], w_ge};
                    r_dvd <= {r_dvd[6:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                end
                FIX: begin
                    r_out_valid <= 1'b1;
                    if (r_b == 4'd0) begin
                        // Divide by zero: fixed quotient, dividend low bits
                        r_out <= {r_a_lo, 4'hF};
                        r_dbz <= 1'b1;
                        r_ovf <= 1'b0;
                    end else begin
                        r_out <= {w_r_final, w_q_final};
                        r_dbz <= 1'b0;
                        r_ovf <= w_q_ovf;
                    end
                end
                DONE: begin
                    // Data stays registered; only the valid flag drops
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = (r_state == IDLE);
    assign s_seq_div4_out = r_out;
    assign dbz            = r_dbz;
    assign ovf            = r_ovf;
    assign out_valid      = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_s_seq_div4.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_seq_div4
// Description : Scoreboard testbench for s_seq_div4. Accepted operands are
//               turned into expected results by an arithmetic reference model
//               and queued; a monitor pops and compares on each new result,
//               checks the 9-cycle latency and that outputs hold in DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_seq_div4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] s_seq_div4_out;
    logic       dbz;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    s_seq_div4 dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .s_seq_div4_out (s_seq_div4_out),
        .dbz            (dbz),
        .ovf            (ovf),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] out;
        logic       dbz;
        logic       ovf;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain signed integer division (truncating toward
    // zero, remainder with the dividend's sign), then range / wrap rules.
    function automatic exp_t model(input logic [7:0] aa, input logic [3:0] bb);
        exp_t e;
        int   ia, ib, qi, ri;
        logic [3:0] q4;
        logic [3:0] r4;
        e.acc_cyc = 0;
        if (bb == 4'd0) begin
            e.out = {aa[3:0], 4'hF};
            e.dbz = 1'b1;
            e.ovf = 1'b0;
        end else begin
            ia = $signed(aa);
            ib = $signed(bb);
            qi = ia / ib;
            ri = ia % ib;
            e.ovf = (qi > 7) || (qi < -8);
            q4 = qi[3:0];
`ifdef S_SEQ_DIV4_OVF_SAT_EN
            if (e.ovf) q4 = (qi > 0) ? 4'h7 : 4'h8;
`endif
            r4 = ri[3:0];
            e.out = {r4, q4};
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Acceptance watcher + result monitor, sampled on the falling edge
    logic       seen = 1'b0;
    logic [9:0] held;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            seen = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(a, b);
                e.acc_cyc = cyc + 1;
                sb.push_back(e);
            end
            if (out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("result", 32'(s_seq_div4_out), 32'(e.out));
                        check("dbz", 32'(dbz), 32'(e.dbz));
                        check("ovf", 32'(ovf), 32'(e.ovf));
                        check("latency", 32'(cyc), 32'(e.acc_cyc + 9));
                    end
                    held = {s_seq_div4_out, dbz, ovf};
                    seen = 1'b1;
                end else begin
                    check("done_hold", 32'({s_seq_div4_out, dbz, ovf}), 32'(held));
                end
                check("in_ready_in_done", 32'(in_ready), 32'd0);
                if (out_ready) seen = 1'b0;
            end
        end
    end

    // Random consumer back-pressure
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("wait_in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [7:0] aa, input logic [3:0] bb);
        int n = 0;
        wait_ready();
        a = aa;
        b = bb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 4'($urandom);
        while (!(sb.size() == 0 && in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("op_timeout", 32'(n), 32'd0);
    endtask

    typedef struct { logic [7:0] a; logic [3:0] b; } op_t;
    op_t dir[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        a        = 8'd0;
        b        = 4'd0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(s_seq_div4_out), 32'd0);
        check("reset_dbz", 32'(dbz), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Directed corner cases
        rdy_rand = 1'b1;
        dir[0] = '{8'hF9, 4'd2};   // -7 / 2
        dir[1] = '{8'd100, 4'd7};  // overflow positive
        dir[2] = '{8'h80, 4'h8};   // -128 / -8 overflow
        dir[3] = '{8'd64, 4'h8};   // 64 / -8 = -8, in range
        dir[4] = '{8'd37, 4'd0};   // divide by zero
        dir[5] = '{8'h80, 4'd1};   // -128 / 1
        foreach (dir[i]) do_op(dir[i].a, dir[i].b);

        // Random operands
        for (int i = 0; i < 150; i++) begin
            do_op(8'($urandom), 4'($urandom));
        end

        // Stall in DONE while pulsing in_valid with fresh operands
        rdy_rand  = 1'b0;
        #0;
        out_ready = 1'b0;
        wait_ready();
        a = 8'hF9;
        b = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom);
            b = 4'($urandom);
            in_valid = 1'(i % 2 == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset mid-calculation aborts the operation
        out_ready = 1'b1;
        a = 8'd50;
        b = 4'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out", 32'(s_seq_div4_out), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_dbz", 32'(dbz), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        begin
            logic saw = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) saw = 1'b1;
            end
            check("abort_no_result", 32'(saw), 32'd0);
        end
        rdy_rand = 1'b1;
        do_op(8'd6, 4'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
